mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters: the fetch path (instruction counter to IR) and the data path (MAR/MDR load/store).
- Arbitrates with a registered req/gnt handshake and sequences the fixed-latency read return.
- Steers read data back to the requester that issued the read.
- Sits between the control unit / datapath and the memory macro, replacing direct memory enables from the control FSM.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..8.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range 1..15.

Ports:
- arb_clk  in  1  clock; all logic on rising edge.
- arb_rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with stable if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse; request accepted.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched word; holds until next fetch return.
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse; request accepted. For stores, this is completion.
- d_rvalid  out  1  one-cycle pulse; d_rdata valid (loads only).
- d_rdata  out  DATA_W  load word; holds until next load return.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  write strobe; only with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- arb_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock, arb_clk. Reset is synchronous and active-high on arb_rst.
- Reset values:
  - All outputs are 0: gnt, rvalid, rdata, mem_*, arb_busy.
  - State = IDLE; wait counter = 0; starvation counter = 0; last-grant flag = fetch.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - On an edge where any req is high, pick a winner. Register mem_en=1, mem_addr/mem_we/mem_wdata from the winner, and the winner's gnt=1 (all visible the next cycle). Go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (the mem_en/gnt cycle, one cycle only):
  - Store: go to IDLE.
  - Load or fetch: go to WAIT; wait counter = 1.
  - mem_en, mem_we and gnt drop to 0 at the next edge. mem_addr/mem_wdata hold.
- WAIT:
  - Counter increments each cycle.
  - In the cycle where counter == MEM_LAT (mem_rdata valid), capture mem_rdata into the issuing requester's rdata and pulse its rvalid next cycle. Go to IDLE.
- Timing summary:
  - mem_en in cycle c gives rvalid in cycle c+MEM_LAT+1.
  - Next grant visible at c+MEM_LAT+2 at the earliest.
  - A store occupies 2 cycles: ISSUE plus IDLE.
- Requests seen outside IDLE are not sampled. A requester that still holds req after its gnt is an illegal stimulus.
- Arbitration (default):
  - Data has fixed priority over fetch.
  - The starvation counter increments on each data grant made while if_req is high. It clears on a fetch grant, or on any IDLE cycle with if_req low.
  - When the counter == STARVE_MAX and if_req is high, fetch wins the contention.
  - The counter saturates at STARVE_MAX.
- Widths:
  - Wait counter: 4 bits.
  - Starvation counter: 4 bits.
  - No address or data arithmetic is performed.
- Reset mid-operation:
  - The in-flight read is discarded; no rvalid is produced even if mem_rdata arrives later.
  - Outputs go to 0 on the reset edge.
- Simultaneous events: rvalid for one requester and gnt for the other never coincide, because the FSM is strictly serial.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Starvation counter and STARVE_MAX are unused.
  - On contention, the winner is the requester not granted last; the last-grant flag is updated on every grant.
  - After reset the flag = fetch, so data wins the first contention.
  - A single requester always wins regardless of the flag.
- Undefined: fixed data priority with the starvation counter, as above.

Test Plan:
- Lone fetch, MEM_LAT=2:
  - Stimulus: reset, then if_req=1, if_addr=0x10 at cycle 0; memory returns 0x00500093.
  - Required: if_gnt, mem_en and mem_addr=0x10 in cycle 1; if_rvalid=1 with if_rdata=0x00500093 in cycle 4; arb_busy high for cycles 1-3.
- Contention, load vs fetch:
  - Stimulus: if_req and d_req (d_we=0, d_addr=0x40) raised in the same cycle.
  - Required: d_gnt first, then d_rvalid; if_gnt one cycle after d_rvalid. rdata routed only to data.
- Store:
  - Stimulus: d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF.
  - Required: one cycle with mem_en=mem_we=1, addr 0x20, data 0xDEADBEEF, and d_gnt. No d_rvalid. Back in IDLE after 2 cycles.
- Starvation, STARVE_MAX=4:
  - Stimulus: back-to-back stores on d_req while if_req is held.
  - Required: exactly 4 d_gnt, then if_gnt; the counter clears and data resumes.
- Reset during WAIT:
  - Stimulus: assert arb_rst one cycle after a fetch gnt.
  - Required: no if_rvalid, all outputs 0, and a following fetch is served with nominal timing.
- Round robin (ARB_ROUND_ROBIN_EN defined):
  - Stimulus: both requesters issue continuous reads.
  - Required: grant order d, i, d, i...

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported unified instruction/data memory between the fetch
// path and the data (MAR/MDR) path. A requester is granted with a one-cycle
// gnt pulse that coincides with the one-cycle mem_en strobe. For reads, the
// arbiter waits for the fixed memory latency, captures mem_rdata and steers it
// to the requester that issued the read, with a one-cycle rvalid pulse.
// Accesses are strictly serial: one access in flight at a time.
//
// Parameters:
//   ADDR_W      address width
//   DATA_W      data width
//   MEM_LAT     cycles from mem_en to valid mem_rdata (1..8)
//   STARVE_MAX  consecutive data grants allowed while fetch waits (1..15)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, contention is resolved round-robin
//                       (the requester not granted last wins) and the
//                       starvation counter is removed. When undefined, data
//                       has fixed priority, bounded by the starvation counter.
//
// Ports:
//   arb_clk, arb_rst          clock, synchronous active-high reset
//   if_req/if_addr            fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata fetch grant pulse, return pulse, returned word
//   d_req/d_we/d_addr/d_wdata data request (load or store), held until d_gnt
//   d_gnt/d_rvalid/d_rdata    data grant pulse, load return pulse, load word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro interface
//   arb_busy                  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              arb_clk,
    input  logic              arb_rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              arb_busy
);

    // state | meaning
    // ------+-----------------------------------------------------------
    // IDLE  | no access in flight; requests sampled, winner registered
    // ISSUE | mem_en/gnt cycle; stores finish here, reads move on to WAIT
    // WAIT  | counting read latency; capture mem_rdata when count hits MEM_LAT
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       owner_d;     // 1: the access in flight belongs to the data path
    logic       fetch_wins;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_gnt_d;  // 1: most recent grant went to the data path

    // Under contention the requester that was not granted last wins.
    always_comb begin
        fetch_wins = if_req && (!d_req || last_gnt_d);
    end
`else
    localparam logic [3:0] STARVE_CNT = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;  // data grants made while fetch was waiting

    // Data normally wins; fetch gets through once data has been granted
    // STARVE_MAX times in a row against a pending fetch.
    always_comb begin
        fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_CNT));
    end
`endif

    always_comb begin
        arb_busy = (state != IDLE);
    end

    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            owner_d    <= 1'b0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_d <= 1'b0;
`else
            starve_cnt <= '0;
`endif
        end else begin
            // Strobes and pulses last exactly one cycle.
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;

            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state  <= ISSUE;
                        mem_en <= 1'b1;
                        if (fetch_wins) begin
                            owner_d  <= 1'b0;
                            if_gnt   <= 1'b1;
                            mem_addr <= if_addr;
                        end else begin
                            owner_d   <= 1'b1;
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_gnt_d <= !fetch_wins;
`endif
                    end
`ifndef ARB_ROUND_ROBIN_EN
                    // With if_req high a grant is always made here, so the
                    // counter either clears (fetch) or counts (data).
                    if (!if_req || fetch_wins) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_CNT) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
`endif
                end

                ISSUE: begin
                    // mem_we still holds this access's write flag here.
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 4'd1;
                    end
                end

                WAIT: begin
                    if (wait_cnt == LAT_CNT) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        if (owner_d) begin
                            d_rdata  <= mem_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    localparam logic [31:0] F0 = 32'h0050_0093;  // word at 0x10
    localparam logic [31:0] F1 = 32'hC0DE_0014;  // word at 0x14
    localparam logic [31:0] D0 = 32'hC0DE_0040;  // word at 0x40

    logic              arb_clk = 1'b0;
    logic              arb_rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              arb_busy;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)
    ) dut (
        .arb_clk(arb_clk), .arb_rst(arb_rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy)
    );

    always #5 arb_clk = ~arb_clk;

    // Memory contents: fixed pattern, independent of the DUT.
    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a == 32'h10) ? F0 : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    // Fixed-latency read pipe; returns zero in cycles with no valid read.
    logic [31:0] pipe [MEM_LAT];
    always @(posedge arb_clk) begin
        pipe[0] <= (mem_en && !mem_we) ? rd(mem_addr) : 32'h0;
        for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[MEM_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        ig, iv, dg, dv, men, mwe, busy;
        logic [31:0] maddr, mwdata, ird, drd;
    } vec_t;

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
        input logic ig, input logic iv, input logic dg, input logic dv,
        input logic men, input logic mwe, input logic busy,
        input logic [31:0] maddr, input logic [31:0] mwdata,
        input logic [31:0] ird, input logic [31:0] drd);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
        v.daddr = daddr; v.dwdata = dwdata;
        v.ig = ig; v.iv = iv; v.dg = dg; v.dv = dv;
        v.men = men; v.mwe = mwe; v.busy = busy;
        v.maddr = maddr; v.mwdata = mwdata; v.ird = ird; v.drd = drd;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".if_gnt"},    32'(if_gnt),    0);
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 0);
        chk({tag, ".if_rdata"},  if_rdata,       0);
        chk({tag, ".d_gnt"},     32'(d_gnt),     0);
        chk({tag, ".d_rvalid"},  32'(d_rvalid),  0);
        chk({tag, ".d_rdata"},   d_rdata,        0);
        chk({tag, ".mem_en"},    32'(mem_en),    0);
        chk({tag, ".mem_we"},    32'(mem_we),    0);
        chk({tag, ".mem_addr"},  mem_addr,       0);
        chk({tag, ".mem_wdata"}, mem_wdata,      0);
        chk({tag, ".arb_busy"},  32'(arb_busy),  0);
    endtask

    task automatic do_reset();
        @(negedge arb_clk);
        arb_rst = 1'b1;
        @(negedge arb_clk);
        @(negedge arb_clk);
        arb_rst = 1'b0;
    endtask

    vec_t        vecs [16];
    logic [15:0] seq;
    logic [15:0] exp_seq;
    int          n_gnt;
    int          got;

    initial begin
        arb_rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

        //             ireq iaddr dreq dwe daddr dwdata        ig iv dg dv men mwe busy maddr mwdata        ird drd
        vecs[0]  = mk(1, 32'h10, 0, 0, 32'h00, 32'h0,          0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h0,          0,  0);
        vecs[1]  = mk(0, 32'h10, 0, 0, 32'h00, 32'h0,          1, 0, 0, 0, 1, 0, 1, 32'h10, 32'h0,          0,  0);
        vecs[2]  = mk(0, 32'h10, 0, 0, 32'h00, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h00, 32'h0,          0,  0);
        vecs[3]  = mk(0, 32'h10, 0, 0, 32'h00, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h00, 32'h0,          0,  0);
        vecs[4]  = mk(1, 32'h14, 1, 0, 32'h40, 32'h0,          0, 1, 0, 0, 0, 0, 0, 32'h00, 32'h0,          F0, 0);
        vecs[5]  = mk(1, 32'h14, 0, 0, 32'h40, 32'h0,          0, 0, 1, 0, 1, 0, 1, 32'h40, 32'h0,          F0, 0);
        vecs[6]  = mk(1, 32'h14, 0, 0, 32'h40, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h00, 32'h0,          F0, 0);
        vecs[7]  = mk(1, 32'h14, 0, 0, 32'h40, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h00, 32'h0,          F0, 0);
        vecs[8]  = mk(1, 32'h14, 0, 0, 32'h40, 32'h0,          0, 0, 0, 1, 0, 0, 0, 32'h00, 32'h0,          F0, D0);
        vecs[9]  = mk(0, 32'h14, 0, 0, 32'h40, 32'h0,          1, 0, 0, 0, 1, 0, 1, 32'h14, 32'h0,          F0, D0);
        vecs[10] = mk(0, 32'h14, 0, 0, 32'h40, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h00, 32'h0,          F0, D0);
        vecs[11] = mk(0, 32'h14, 0, 0, 32'h40, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h00, 32'h0,          F0, D0);
        vecs[12] = mk(0, 32'h14, 1, 1, 32'h20, 32'hDEADBEEF,   0, 1, 0, 0, 0, 0, 0, 32'h00, 32'h0,          F1, D0);
        vecs[13] = mk(0, 32'h14, 0, 0, 32'h20, 32'hDEADBEEF,   0, 0, 1, 0, 1, 1, 1, 32'h20, 32'hDEADBEEF,   F1, D0);
        vecs[14] = mk(0, 32'h14, 0, 0, 32'h20, 32'hDEADBEEF,   0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h0,          F1, D0);
        vecs[15] = mk(0, 32'h14, 0, 0, 32'h20, 32'hDEADBEEF,   0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h0,          F1, D0);

        // Reset state.
        @(negedge arb_clk);
        @(negedge arb_clk);
        chk_all_zero("reset");
        arb_rst = 1'b0;

        // Lone fetch, load-vs-fetch contention, store.
        for (int i = 0; i < 16; i++) begin
            @(negedge arb_clk);
            if_req  = vecs[i].ireq;
            if_addr = vecs[i].iaddr;
            d_req   = vecs[i].dreq;
            d_we    = vecs[i].dwe;
            d_addr  = vecs[i].daddr;
            d_wdata = vecs[i].dwdata;
            chk($sformatf("v%0d.if_gnt", i),    32'(if_gnt),    32'(vecs[i].ig));
            chk($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].iv));
            chk($sformatf("v%0d.d_gnt", i),     32'(d_gnt),     32'(vecs[i].dg));
            chk($sformatf("v%0d.d_rvalid", i),  32'(d_rvalid),  32'(vecs[i].dv));
            chk($sformatf("v%0d.mem_en", i),    32'(mem_en),    32'(vecs[i].men));
            chk($sformatf("v%0d.mem_we", i),    32'(mem_we),    32'(vecs[i].mwe));
            chk($sformatf("v%0d.arb_busy", i),  32'(arb_busy),  32'(vecs[i].busy));
            chk($sformatf("v%0d.if_rdata", i),  if_rdata,       vecs[i].ird);
            chk($sformatf("v%0d.d_rdata", i),   d_rdata,        vecs[i].drd);
            if (vecs[i].men)
                chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].maddr);
            if (vecs[i].mwe)
                chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].mwdata);
        end

        // Reset one cycle after a fetch grant: the read is dropped.
        @(negedge arb_clk);
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge arb_clk);
        chk("rstwait.if_gnt", 32'(if_gnt), 1);
        if_req = 1'b0;
        @(negedge arb_clk);
        arb_rst = 1'b1;
        @(negedge arb_clk);
        arb_rst = 1'b0;
        chk_all_zero("rstwait");
        for (int k = 0; k < 4; k++) begin
            @(negedge arb_clk);
            chk($sformatf("rstwait.no_rvalid%0d", k), 32'(if_rvalid), 0);
            chk($sformatf("rstwait.if_rdata%0d", k),  if_rdata,       0);
        end
        // Following fetch with nominal timing.
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge arb_clk);
        chk("refetch.if_gnt", 32'(if_gnt), 1);
        chk("refetch.mem_addr", mem_addr, 32'h10);
        if_req = 1'b0;
        @(negedge arb_clk);
        chk("refetch.rvalid_early", 32'(if_rvalid), 0);
        @(negedge arb_clk);
        chk("refetch.rvalid_early", 32'(if_rvalid), 0);
        @(negedge arb_clk);
        chk("refetch.if_rvalid", 32'(if_rvalid), 1);
        chk("refetch.if_rdata", if_rdata, F0);

        // Grant order under continuous requests from both sides.
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        n_gnt   = 6;
        exp_seq = 16'b0000_0000_0001_0101;  // bit i = 1: grant i went to data
        d_we    = 1'b0;
`else
        n_gnt   = 10;
        exp_seq = 16'b0000_0001_1110_1111;  // d d d d i d d d d i
        d_we    = 1'b1;
`endif
        if_req = 1'b1; if_addr = 32'h30;
        d_req  = 1'b1; d_addr  = 32'h50; d_wdata = 32'h1234_5678;
        seq = '0;
        got = 0;
        for (int cyc = 0; cyc < 300 && got < n_gnt; cyc++) begin
            @(negedge arb_clk);
            if (if_gnt && d_gnt) chk("grants.both_gnt", 32'(d_gnt), 0);
            if (d_gnt) begin
                seq[got] = 1'b1;
                got++;
            end else if (if_gnt) begin
                seq[got] = 1'b0;
                got++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("grants.count", 32'(got), 32'(n_gnt));
        for (int g = 0; g < n_gnt; g++)
            chk($sformatf("grants.order%0d_is_data", g), 32'(seq[g]), 32'(exp_seq[g]));

        repeat (6) @(negedge arb_clk);
        chk("end.arb_busy", 32'(arb_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
